alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The port list SHALL be, in order: x, y, zx, nx, zy, ny, f, no, out, zr, ng, clk, rst, out_r, zr_r, ng_r; every port is listed below with clock and reset first.
REQ-002 clk  input  1  single clock for the registered result stage; all registers update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 x  input  16  operand X, two's complement.
REQ-005 y  input  16  operand Y, two's complement.
REQ-006 zx  input  1  zero X before all other processing.
REQ-007 nx  input  1  bitwise-invert X, after zx.
REQ-008 zy  input  1  zero Y before all other processing.
REQ-009 ny  input  1  bitwise-invert Y, after zy.
REQ-010 f  input  1  function select: 1 = add, 0 = bitwise AND.
REQ-011 no  input  1  bitwise-invert the function result.
REQ-012 out  output  16  combinational result.
REQ-013 zr  output  1  combinational flag, 1 when out is zero.
REQ-014 ng  output  1  combinational flag, 1 when out is negative.
REQ-015 out_r  output  16  registered copy of out.
REQ-016 zr_r  output  1  registered copy of zr.
REQ-017 ng_r  output  1  registered copy of ng.

Function
REQ-018 Stage 1: xa = zx ? 16'h0000 : x; ya = zy ? 16'h0000 : y.
REQ-019 Stage 2: xb = nx ? ~xa : xa; yb = ny ? ~ya : ya.
REQ-020 Stage 3: r = f ? (xb + yb) mod 2^16 : (xb & yb); the carry out of bit 15 SHALL be discarded.
REQ-021 Stage 4: out = no ? ~r : r.
REQ-022 zr SHALL be 1 exactly when out == 16'h0000, otherwise 0.
REQ-023 ng SHALL equal out[15].
REQ-024 out, zr and ng SHALL be purely combinational, with zero clock latency.
REQ-025 out, zr and ng SHALL settle within one time unit of any input change, and SHALL NOT depend on clk or rst.
REQ-026 All 64 control combinations SHALL be legal, and no output is undefined for any combination.
REQ-027 On each rising clk edge while rst is low, out_r, zr_r and ng_r SHALL capture out, zr and ng; registered latency is exactly 1 cycle.
REQ-028 The combinational outputs SHALL have no state and no handshake.

Reset
REQ-029 While rst is high, out_r SHALL be 16'h0000, zr_r SHALL be 1 and ng_r SHALL be 0, asynchronously and independent of clk.
REQ-030 rst asserted mid-operation SHALL force the reset values immediately.
REQ-031 rst SHALL NOT affect out, zr or ng.
REQ-032 The first capture SHALL occur on the first rising clk edge after rst deasserts.

Verification
REQ-033 x=0000, y=FFFF, zx nx zy ny f no = 101010 (constant 0) -> out=0000, zr=1, ng=0; 111111 (constant 1) -> out=0001, zr=0, ng=0; 111010 (constant -1) -> out=FFFF, zr=0, ng=1.
REQ-034 x=0011, y=0003: 000010 (x+y) -> 0014; 010011 (x-y) -> 000E; 000111 (y-x) -> FFF2 with ng=1; 000000 (x&y) -> 0001; 010101 (x|y) -> 0013.
REQ-035 x=0011, y=0003, unary operations: 001100 (x) -> 0011; 110000 (y) -> 0003; 001101 (!x) -> FFEE with ng=1; 001111 (-x) -> FFEF; 011111 (x+1) -> 0012; 110111 (y+1) -> 0004; 001110 (x-1) -> 0010; 110010 (y-1) -> 0002.
REQ-036 Overflow wrap: x=FFFF, y=0001, control 000010 -> out=0000, zr=1, ng=0.
REQ-037 Reset and register stage: assert rst mid-run -> out_r=0000, zr_r=1, ng_r=0 immediately while out keeps tracking the inputs; after deassert, one rising clk edge -> out_r equals the previous cycle's out.
REQ-038 Every REQ-033 to REQ-036 vector SHALL be checked 1 time unit after the inputs are applied, with out, zr and ng all compared.

Source files
------------

// File: rtl/alu.sv
// 16-bit Hack-style ALU: a combinational result and flags, plus a registered copy
// of them that resets asynchronously.
module alu #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         zx,
  input  logic         nx,
  input  logic         zy,
  input  logic         ny,
  input  logic         f,
  input  logic         no,
  output logic [W-1:0] out,
  output logic         zr,
  output logic         ng,
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] out_r,
  output logic         zr_r,
  output logic         ng_r
);

  logic [W-1:0] xa, ya, xb, yb, r;
  logic [W-1:0] out_d, out_q;
  logic         zr_d, zr_q, ng_d, ng_q;

  // Operand conditioning comes first: zero, then invert. The add drops its carry out.
  always_comb begin
    xa    = zx ? '0 : x;
    ya    = zy ? '0 : y;
    xb    = nx ? ~xa : xa;
    yb    = ny ? ~ya : ya;
    r     = f ? (xb + yb) : (xb & yb);
    out_d = no ? ~r : r;
    zr_d  = (out_d == '0);
    ng_d  = out_d[W-1];
  end

  assign out = out_d;
  assign zr  = zr_d;
  assign ng  = ng_d;

  // The reset value holds a zero result, so the registered flags agree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      zr_q  <= 1'b1;
      ng_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      zr_q  <= zr_d;
      ng_q  <= ng_d;
    end
  end

  assign out_r = out_q;
  assign zr_r  = zr_q;
  assign ng_r  = ng_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: known vectors, random operations and reset behaviour.
// The registered path is checked through an expected-value queue.
module tb_alu;

  logic [15:0] x, y, out, out_r;
  logic        zx, nx, zy, ny, f, no;
  logic        zr, ng, zr_r, ng_r;
  logic        clk, rst;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] o;
    logic        z;
    logic        n;
  } exp_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  c;
    logic [15:0] o;
  } vec_t;

  exp_t q[$];

  alu dut (
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out(out), .zr(zr), .ng(ng), .clk(clk), .rst(rst),
    .out_r(out_r), .zr_r(zr_r), .ng_r(ng_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written as plain integer arithmetic.
  function automatic logic [15:0] model(input logic [15:0] xv, input logic [15:0] yv,
                                        input logic [5:0] c);
    int a, b, res;
    a = c[5] ? 0 : int'(xv);
    if (c[4]) a = 65535 - a;
    b = c[3] ? 0 : int'(yv);
    if (c[2]) b = 65535 - b;
    res = c[1] ? ((a + b) % 65536) : (a & b);
    if (c[0]) res = 65535 - res;
    return res[15:0];
  endfunction

  // Control order is zx nx zy ny f no, with zx in the MSB.
  task automatic drive(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] c);
    x = xv; y = yv;
    {zx, nx, zy, ny, f, no} = c;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(16'h0011, 16'h0003, 6'b000010);
    #1;
    n_checks++;
    if (out_r !== 16'h0000 || zr_r !== 1'b1 || ng_r !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got out_r=%h zr_r=%b ng_r=%b want 0000 1 0", out_r, zr_r, ng_r);
    end
    n_checks++;
    if (out !== 16'h0014 || zr !== 1'b0 || ng !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_comb: got out=%h zr=%b ng=%b want 0014 0 0", out, zr, ng);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Spec vectors: check the combinational outputs 1 time unit after they are applied,
  // then the registered copy after the next rising edge.
  task automatic test_vectors;
    vec_t v[17];
    exp_t e, g;
    v[0]  = '{16'h0000, 16'hFFFF, 6'b101010, 16'h0000};
    v[1]  = '{16'h0000, 16'hFFFF, 6'b111111, 16'h0001};
    v[2]  = '{16'h0000, 16'hFFFF, 6'b111010, 16'hFFFF};
    v[3]  = '{16'h0011, 16'h0003, 6'b000010, 16'h0014};
    v[4]  = '{16'h0011, 16'h0003, 6'b010011, 16'h000E};
    v[5]  = '{16'h0011, 16'h0003, 6'b000111, 16'hFFF2};
    v[6]  = '{16'h0011, 16'h0003, 6'b000000, 16'h0001};
    v[7]  = '{16'h0011, 16'h0003, 6'b010101, 16'h0013};
    v[8]  = '{16'h0011, 16'h0003, 6'b001100, 16'h0011};
    v[9]  = '{16'h0011, 16'h0003, 6'b110000, 16'h0003};
    v[10] = '{16'h0011, 16'h0003, 6'b001101, 16'hFFEE};
    v[11] = '{16'h0011, 16'h0003, 6'b001111, 16'hFFEF};
    v[12] = '{16'h0011, 16'h0003, 6'b011111, 16'h0012};
    v[13] = '{16'h0011, 16'h0003, 6'b110111, 16'h0004};
    v[14] = '{16'h0011, 16'h0003, 6'b001110, 16'h0010};
    v[15] = '{16'h0011, 16'h0003, 6'b110010, 16'h0002};
    v[16] = '{16'hFFFF, 16'h0001, 6'b000010, 16'h0000};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(v[i].x, v[i].y, v[i].c);
      e = '{v[i].o, (v[i].o == 16'h0000), v[i].o[15]};
      q.push_back(e);
      #1;
      n_checks++;
      if (out !== e.o || zr !== e.z || ng !== e.n) begin
        n_fail++;
        $display("FAIL vec%0d_comb: got out=%h zr=%b ng=%b want %h %b %b",
                 i, out, zr, ng, e.o, e.z, e.n);
      end
      @(posedge clk);
      #1;
      g = q.pop_front();
      n_checks++;
      if (out_r !== g.o || zr_r !== g.z || ng_r !== g.n) begin
        n_fail++;
        $display("FAIL vec%0d_reg: got out_r=%h zr_r=%b ng_r=%b want %h %b %b",
                 i, out_r, zr_r, ng_r, g.o, g.z, g.n);
      end
    end
  endtask

  // A new operation every cycle. The register must still show the previous result
  // until the clock edge, then the new one.
  task automatic test_back_to_back;
    logic [15:0] xv, yv, o;
    logic [5:0]  c;
    exp_t e, g, prev;
    prev = '{out_r, zr_r, ng_r};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      xv = 16'($urandom); yv = 16'($urandom); c = 6'($urandom);
      if (i < 4) begin xv = 16'h8000; yv = 16'h8000; c = 6'b000010; end
      drive(xv, yv, c);
      o = model(xv, yv, c);
      e = '{o, (o == 16'h0000), o[15]};
      q.push_back(e);
      #1;
      n_checks++;
      if (out !== e.o || zr !== e.z || ng !== e.n) begin
        n_fail++;
        $display("FAIL rnd%0d_comb x=%h y=%h c=%b: got %h %b %b want %h %b %b",
                 i, xv, yv, c, out, zr, ng, e.o, e.z, e.n);
      end
      n_checks++;
      if (out_r !== prev.o || zr_r !== prev.z || ng_r !== prev.n) begin
        n_fail++;
        $display("FAIL rnd%0d_hold: got out_r=%h want %h", i, out_r, prev.o);
      end
      @(posedge clk);
      #1;
      g = q.pop_front();
      n_checks++;
      if (out_r !== g.o || zr_r !== g.z || ng_r !== g.n) begin
        n_fail++;
        $display("FAIL rnd%0d_reg: got out_r=%h zr_r=%b ng_r=%b want %h %b %b",
                 i, out_r, zr_r, ng_r, g.o, g.z, g.n);
      end
      prev = g;
    end
  endtask

  // Assert reset between clock edges: the register clears at once while the
  // combinational path keeps following the inputs.
  task automatic test_mid_reset;
    @(negedge clk);
    drive(16'h0011, 16'h0003, 6'b000111);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_r !== 16'h0000 || zr_r !== 1'b1 || ng_r !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_regs: got out_r=%h zr_r=%b ng_r=%b want 0000 1 0", out_r, zr_r, ng_r);
    end
    n_checks++;
    if (out !== 16'hFFF2 || zr !== 1'b0 || ng !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_comb: got out=%h zr=%b ng=%b want FFF2 0 1", out, zr, ng);
    end
    drive(16'h0011, 16'h0003, 6'b010101);
    #1;
    n_checks++;
    if (out !== 16'h0013 || zr !== 1'b0 || ng !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_track: got out=%h want 0013", out);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_r !== 16'h0000 || zr_r !== 1'b1 || ng_r !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_held: got out_r=%h zr_r=%b ng_r=%b want 0000 1 0", out_r, zr_r, ng_r);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_r !== 16'h0000 || zr_r !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_release: got out_r=%h zr_r=%b want 0000 1", out_r, zr_r);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (out_r !== 16'h0013 || zr_r !== 1'b0 || ng_r !== 1'b0) begin
      n_fail++;
      $display("FAIL first_capture: got out_r=%h zr_r=%b ng_r=%b want 0013 0 0", out_r, zr_r, ng_r);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
